// File: rtl/alocador_vozes_if.sv
`default_nettype none
// ============================================================================
//  Module   : alocador_vozes_if
//  Purpose  : Bundles the key inputs and the per-voice outputs of the voice
//             allocator.
//  Signals  : teclas        raw key levels, 1 = pressed (asynchronous)
//             voz_ativa     gate per voice
//             voz_tecla     key index per voice, voice v at [v*W_IDX +: W_IDX]
//             voz_disparo   one-cycle pulse when a voice is (re)assigned
//             voz_liberando 1 while a voice is in release hold
//             voz_roubo     one-cycle pulse when an active voice was stolen
//  Modports : slave  - allocator side
//             master - key source / voice generator side
//  Revision : 1.0 - initial release
// ============================================================================
interface alocador_vozes_if #(
  parameter int N_TECLAS = 10,
  parameter int N_VOZES  = 4,
  parameter int W_IDX    = 4
);
  logic [N_TECLAS-1:0]      teclas;
  logic [N_VOZES-1:0]       voz_ativa;
  logic [N_VOZES*W_IDX-1:0] voz_tecla;
  logic [N_VOZES-1:0]       voz_disparo;
  logic [N_VOZES-1:0]       voz_liberando;
  logic                     voz_roubo;

  modport slave (
    input  teclas,
    output voz_ativa, voz_tecla, voz_disparo, voz_liberando, voz_roubo
  );

  modport master (
    output teclas,
    input  voz_ativa, voz_tecla, voz_disparo, voz_liberando, voz_roubo
  );
endinterface
`default_nettype wire

// File: rtl/alocador_vozes.sv
`default_nettype none
// ============================================================================
//  Module   : alocador_vozes
//  Purpose  : Polyphonic voice allocator. Scans the synchronised key vector
//             one key per cycle, detects press/release events and maps each
//             pressed key onto one of N_VOZES voices (retrigger, free voice,
//             releasing voice, or steal the oldest active voice).
//  Ports    : clk   - system clock, rising edge
//             rst_n - synchronous reset, active low
//             bus   - alocador_vozes_if.slave (keys in, voice outputs out)
//  Revision : 1.0 - initial release
// ============================================================================
module alocador_vozes #(
  parameter int N_TECLAS   = 10,
  parameter int N_VOZES    = 4,
  parameter int W_IDX      = 4,
  parameter int REL_CICLOS = 1024,
  parameter int W_IDADE    = 8
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  alocador_vozes_if.slave    bus
);

  localparam int W_REL = (REL_CICLOS > 1) ? $clog2(REL_CICLOS) : 1;
  localparam int W_VOZ = (N_VOZES > 1) ? $clog2(N_VOZES) : 1;
  localparam logic [W_REL-1:0]   C_REL_INI   = W_REL'(REL_CICLOS - 1);
  localparam logic [W_IDADE-1:0] C_IDADE_MAX = '1;
  localparam logic [W_IDX-1:0]   C_IDX_ULT   = W_IDX'(N_TECLAS - 1);

  typedef enum logic [1:0] {
    LIVRE     = 2'd0,
    ATIVA     = 2'd1,
    LIBERANDO = 2'd2
  } estado_voz_t;

  // Key synchroniser, scanner and per-key "press processed" flags
  logic [N_TECLAS-1:0] r_sync1;
  logic [N_TECLAS-1:0] r_teclas_s;
  logic [N_TECLAS-1:0] r_estado;
  logic [W_IDX-1:0]    r_idx;

  // Per-voice state
  estado_voz_t         r_voz   [N_VOZES];
  logic [W_REL-1:0]    r_rel   [N_VOZES];
  logic [W_IDADE-1:0]  r_idade [N_VOZES];
  logic [W_IDX-1:0]    r_tecla [N_VOZES];
  logic [N_VOZES-1:0]  r_ativa;
  logic [N_VOZES-1:0]  r_liberando;
  logic [N_VOZES-1:0]  r_disparo;
  logic                r_roubo;

  estado_voz_t         w_voz_nxt   [N_VOZES];
  logic [W_REL-1:0]    w_rel_nxt   [N_VOZES];
  logic [W_IDADE-1:0]  w_idade_nxt [N_VOZES];
  logic [W_IDX-1:0]    w_tecla_nxt [N_VOZES];
  logic [N_VOZES-1:0]  w_disparo_nxt;
  logic                w_roubo_nxt;

  // Event detection on the key currently under the scanner
  logic w_tecla_s, w_press, w_release;
  assign w_tecla_s = r_teclas_s[r_idx];
  assign w_press   =  w_tecla_s & ~r_estado[r_idx];
  assign w_release = ~w_tecla_s &  r_estado[r_idx];

  // Candidate search for every allocation rule; priority applied afterwards
  logic               w_ach_ret, w_ach_livre, w_ach_lib, w_ach_ativa, w_ach_sol;
  logic [W_VOZ-1:0]   w_sel_ret, w_sel_livre, w_sel_lib, w_sel_velha, w_sel_sol;
  logic [W_IDADE-1:0] w_idade_max;
  logic [W_VOZ-1:0]   w_sel;
  logic               w_roubar;

  always_comb begin
    w_ach_ret   = 1'b0;  w_sel_ret   = '0;
    w_ach_livre = 1'b0;  w_sel_livre = '0;
    w_ach_lib   = 1'b0;  w_sel_lib   = '0;
    w_ach_ativa = 1'b0;  w_sel_velha = '0;  w_idade_max = '0;
    w_ach_sol   = 1'b0;  w_sel_sol   = '0;
    for (int v = 0; v < N_VOZES; v++) begin
      if (r_voz[v] == LIBERANDO && r_tecla[v] == r_idx && !w_ach_ret) begin
        w_ach_ret = 1'b1;  w_sel_ret = W_VOZ'(v);
      end
      if (r_voz[v] == LIVRE && !w_ach_livre) begin
        w_ach_livre = 1'b1;  w_sel_livre = W_VOZ'(v);
      end
      if (r_voz[v] == LIBERANDO && !w_ach_lib) begin
        w_ach_lib = 1'b1;  w_sel_lib = W_VOZ'(v);
      end
      // Strict '>' while scanning upwards keeps ties on the lowest index
      if (r_voz[v] == ATIVA && (!w_ach_ativa || r_idade[v] > w_idade_max)) begin
        w_ach_ativa = 1'b1;  w_idade_max = r_idade[v];  w_sel_velha = W_VOZ'(v);
      end
      // Voice currently sounding this key, used on release
      if (r_voz[v] == ATIVA && r_tecla[v] == r_idx && !w_ach_sol) begin
        w_ach_sol = 1'b1;  w_sel_sol = W_VOZ'(v);
      end
    end

    w_roubar = 1'b0;
    if (w_ach_ret)        w_sel = w_sel_ret;
    else if (w_ach_livre) w_sel = w_sel_livre;
    else if (w_ach_lib)   w_sel = w_sel_lib;
    else begin
      w_sel    = w_sel_velha;
      w_roubar = w_ach_ativa;
    end
  end

  // Voice next-state logic
  always_comb begin
    w_roubo_nxt = w_press & w_roubar;
    for (int v = 0; v < N_VOZES; v++) begin
      w_voz_nxt[v]     = r_voz[v];
      w_rel_nxt[v]     = r_rel[v];
      w_idade_nxt[v]   = r_idade[v];
      w_tecla_nxt[v]   = r_tecla[v];
      w_disparo_nxt[v] = 1'b0;

      case (r_voz[v])
        ATIVA: begin
          if (r_idade[v] != C_IDADE_MAX) w_idade_nxt[v] = r_idade[v] + 1'b1;
        end
        LIBERANDO: begin
          if (r_rel[v] == '0) w_voz_nxt[v] = LIVRE;
          else                w_rel_nxt[v] = r_rel[v] - 1'b1;
        end
        default: ;
      endcase

      if (w_press && w_sel == W_VOZ'(v)) begin
        w_voz_nxt[v]     = ATIVA;
        w_tecla_nxt[v]   = r_idx;
        w_idade_nxt[v]   = '0;
        w_disparo_nxt[v] = 1'b1;
      end else if (w_release && w_ach_sol && w_sel_sol == W_VOZ'(v)) begin
        w_voz_nxt[v] = LIBERANDO;
        w_rel_nxt[v] = C_REL_INI;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1     <= '0;
      r_teclas_s  <= '0;
      r_estado    <= '0;
      r_idx       <= '0;
      r_ativa     <= '0;
      r_liberando <= '0;
      r_disparo   <= '0;
      r_roubo     <= 1'b0;
      for (int v = 0; v < N_VOZES; v++) begin
        r_voz[v]   <= LIVRE;
        r_rel[v]   <= '0;
        r_idade[v] <= '0;
        r_tecla[v] <= '0;
      end
    end else begin
      r_sync1    <= bus.teclas;
      r_teclas_s <= r_sync1;
      r_idx      <= (r_idx == C_IDX_ULT) ? '0 : r_idx + 1'b1;
      if (w_press)   r_estado[r_idx] <= 1'b1;
      if (w_release) r_estado[r_idx] <= 1'b0;
      r_disparo <= w_disparo_nxt;
      r_roubo   <= w_roubo_nxt;
      for (int v = 0; v < N_VOZES; v++) begin
        r_voz[v]       <= w_voz_nxt[v];
        r_rel[v]       <= w_rel_nxt[v];
        r_idade[v]     <= w_idade_nxt[v];
        r_tecla[v]     <= w_tecla_nxt[v];
        r_ativa[v]     <= (w_voz_nxt[v] == ATIVA);
        r_liberando[v] <= (w_voz_nxt[v] == LIBERANDO);
      end
    end
  end

  assign bus.voz_ativa     = r_ativa;
  assign bus.voz_liberando = r_liberando;
  assign bus.voz_disparo   = r_disparo;
  assign bus.voz_roubo     = r_roubo;

  generate
    for (genvar v = 0; v < N_VOZES; v++) begin : g_saida
      assign bus.voz_tecla[v*W_IDX +: W_IDX] = r_tecla[v];
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/alocador_vozes.md
Name: alocador_vozes

Overview:
Polyphonic voice allocator between the key inputs and a bank of N_VOZES voice generators, with fewer voices than keys.
Scans the key vector round-robin and detects press/release events. Assigns each pressed key to a voice, retriggering, reusing or stealing voices by fixed priority.
Per voice it drives a gate, the key index that voice plays, and a trigger pulse. Downstream period mapping and the clk2prox/instrumento stages are fed from these outputs.

Parameters:
N_TECLAS, 10, number of key inputs
N_VOZES, 4, number of voice generators shared between keys
W_IDX, 4, width of a key index (must satisfy 2^W_IDX >= N_TECLAS)
REL_CICLOS, 1024, release-hold duration in clk cycles (>= 1)
W_IDADE, 8, width of per-voice saturating age counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active low
teclas  in  N_TECLAS  raw key levels, 1 = pressed, asynchronous
voz_ativa  out  N_VOZES  gate per voice, 1 = key held
voz_tecla  out  N_VOZES*W_IDX  key index per voice, voice v at bits [v*W_IDX +: W_IDX]
voz_disparo  out  N_VOZES  one-cycle pulse when a voice is (re)assigned
voz_liberando  out  N_VOZES  1 while voice is in release hold
voz_roubo  out  1  one-cycle pulse when an ATIVA voice was stolen

Behaviour:
- Input sync: teclas passes through 2 flops → teclas_s.
- Scanner: idx counts 0..N_TECLAS-1, +1 every cycle, wraps to 0. Exactly one key is evaluated per cycle.
- estado[k] marks a press as processed. Press event: teclas_s[idx]=1 and estado[idx]=0. Release event: teclas_s[idx]=0 and estado[idx]=1. The event updates estado[idx] in the same cycle.
- Voice FSM, one per voice:
  - LIVRE: gate 0, liberando 0.
  - ATIVA: gate 1.
  - LIBERANDO: gate 0, liberando 1, counter rel.
- Press on key k. First match wins:
  1. A LIBERANDO voice holding k: retrigger it.
  2. Lowest-index LIVRE voice.
  3. Lowest-index LIBERANDO voice.
  4. ATIVA voice with largest age, ties to lowest index; voz_roubo=1.
  - The chosen voice becomes ATIVA, voz_tecla=k, age=0, voz_disparo[v]=1 for one cycle.
- Release on key k:
  - The ATIVA voice with voz_tecla=k goes to LIBERANDO with rel=REL_CICLOS-1.
  - If no ATIVA voice holds k (its voice was stolen), only estado is cleared.
- LIBERANDO: rel decrements each cycle; at rel=0 the next state is LIVRE. voz_tecla is retained in LIBERANDO and LIVRE.
- Age: +1 per cycle in ATIVA, saturates at 2^W_IDADE-1, cleared on assignment.
- All outputs are registered. An event evaluated in cycle t is visible at t+1.
- Worst-case key-change→output latency: 2 + N_TECLAS + 1 cycles.
- Max one event per cycle, so voices never see simultaneous press and release.
- Reset (synchronous, also mid-operation) clears to 0: idx, estado, sync flops, voz_ativa, voz_tecla, voz_disparo, voz_liberando, voz_roubo, all ages and rel counters. All voices go to LIVRE. Keys still held after reset re-fire as new presses.

Test Plan:
- Reset, then teclas=10'b11111_11111 held → first scan assigns keys 0,1,2,3 to voices 0..3. Keys 4..9 steal v0,v1,v2,v3,v0,v1. Final voz_tecla = {v3=7, v2=6, v1=9, v0=8}, all gates 1. Exactly 10 disparo pulses and 6 voz_roubo pulses; no further events in the second scan.
- Only key 5 pressed after reset → within 13 cycles voz_ativa=4'b0001, voz_tecla[v0]=5, a single voz_disparo[0] pulse; other voices stay LIVRE.
- Release key 5 → voz_ativa[0]=0, voz_liberando[0]=1 for exactly REL_CICLOS cycles, then 0; voz_tecla[v0] stays 5.
- Re-press key 5 with key 2 also held, during key 5's release → voice 0 retriggered (not voice 1 or 2): disparo[0] pulse, liberando[0]=0, gate 1.
- Steal case: release a key whose voice was stolen → no change to any voice output. Re-press it → normal allocation.
- Assert rst_n=0 for one cycle while keys are held and one voice is in LIBERANDO → all outputs 0 the next cycle. After release of reset, held keys are reallocated from voice 0.
